serial_rx_unstripe: RTL and testbench
=====================================

SERIAL_RX_UNSTRIPE -- requirements
Module: serial_rx_unstripe

Interface
REQ-001 SHALL have no parameters; every constant is fixed in the package (see Structure).
REQ-002 clk_8f  input  1  bit clock; one serial bit per rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 serial_in  input  1  serial bitstream, MSB of each byte first.
REQ-005 data_out_0  output  8  lane-0 byte; holds its value until the next lane-0 byte.
REQ-006 valid_out_0  output  1  one-cycle strobe qualifying data_out_0.
REQ-007 data_out_1  output  8  lane-1 byte; holds its value until the next lane-1 byte.
REQ-008 valid_out_1  output  1  one-cycle strobe qualifying data_out_1.
REQ-009 active  output  1  high while byte alignment is locked.
REQ-010 byte_count  output  8  received-data-byte counter; present only when RX_STATS_EN is defined.

Function
REQ-011 SHALL shift serial_in into an 8-bit register every clk_8f edge: shreg <= {shreg[6:0], serial_in}.
REQ-012 SHALL implement states ALIGN, LOCK and ACTIVE; the reset state is ALIGN.
REQ-013 ALIGN: SHALL compare the post-shift byte with COMMA (8'hBC) every cycle.
- On a match, SHALL clear the bit counter (byte boundary), set comma count to 1 and go to LOCK.
REQ-014 A 3-bit bit counter SHALL wrap from 7 to 0; a byte completes on each edge where it wraps.
REQ-015 LOCK: on each completed byte, SHALL increment comma count if the byte equals COMMA.
- SHALL otherwise return to ALIGN with comma count 0.
- SHALL go to ACTIVE when comma count reaches 4 (the 4th consecutive aligned comma).
REQ-016 active SHALL be registered: high from the edge that enters ACTIVE, low in ALIGN and LOCK.
REQ-017 ACTIVE, completed byte equal to COMMA: idle; SHALL raise no valid and SHALL reset the lane pointer to 0.
REQ-018 ACTIVE, completed byte not equal to COMMA: data; SHALL send it to the lane given by the lane pointer, then toggle the pointer.
REQ-019 Latency: a byte whose last bit is sampled at edge N SHALL appear as data_out_x with valid_out_x high in the cycle after edge N+1.
- valid_out_x SHALL be high for exactly one cycle per byte.
REQ-020 valid_out_0 and valid_out_1 SHALL never be high in the same cycle.
REQ-021 ACTIVE SHALL be left only by reset; there is no loss-of-lock detection.
REQ-022 A comma pattern straddling a byte boundary in ACTIVE SHALL be ignored; only aligned bytes are decoded.

Reset
REQ-023 reset low SHALL asynchronously clear all of the following:
- state to ALIGN; shreg, bit counter, comma count and lane pointer to 0;
- data_out_0, data_out_1, valid_out_0, valid_out_1 and active to 0;
- byte_count to 0 when RX_STATS_EN is defined.
REQ-024 Reset asserted mid-byte or mid-LOCK SHALL discard partial state; realignment SHALL require 4 fresh commas.

Configuration
REQ-025 With macro RX_STATS_EN defined: byte_count SHALL increment by 1 per data byte in ACTIVE and saturate at 8'hFF.
REQ-026 Without RX_STATS_EN: the byte_count port and counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-027 Shared package SHALL hold:
- COMMA = 8'hBC and COMMA_LOCK_COUNT = 4;
- the state enum {ALIGN, LOCK, ACTIVE};
- the lane-index type.
REQ-028 SHALL contain one sub-module, serial_to_byte: shift register, bit counter and byte-done strobe.
- The FSM and the unstriping SHALL sit in the top module.

Verification
REQ-029 Verification scenarios:
- Reset low 4 cycles, then stream of 8'hBC x6 -> active rises after the 4th aligned comma; no valids.
- After lock, send A4,32,FF,00 -> valid_out_0 with A4, valid_out_1 with 32, lane0 FF, lane1 00; each strobe lasts one cycle.
- Send FF, BC, EE -> lane0 FF, idle, lane0 EE (pointer reset by the comma).
- In LOCK after 2 commas, send 8'h55 -> back to ALIGN, active stays 0; 4 more commas then lock.
- Lead with 3 random bits, then commas -> alignment found at an arbitrary bit offset; data bytes decoded correctly.
- Reset pulsed low mid-data -> all outputs 0 immediately; active returns only after 4 new commas.
- With RX_STATS_EN: 300 data bytes -> byte_count = 8'hFF.

Source files
------------

// File: rtl/serial_rx_unstripe_pkg.sv
// Shared constants and types for the serial receive unstriper.
package serial_rx_unstripe_pkg;

   localparam logic [7:0] COMMA = 8'hBC;
   localparam logic [2:0] COMMA_LOCK_COUNT = 3'd4;

   typedef enum logic [1:0] {
      ALIGN,
      LOCK,
      ACTIVE
   } rx_state_e;

   typedef logic [0:0] lane_idx_t;
   typedef logic [2:0] comma_cnt_t;

endpackage

// File: rtl/serial_rx_unstripe_s2b.sv
// Serial-to-byte front end: shift register, wrapping bit counter, byte-done strobe.
module serial_to_byte (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       serial_in,
   input  logic       realign,
   output logic [7:0] byte_val,
   output logic       byte_done
);

   logic [7:0] shreg_q, shreg_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;

   always_comb begin
      shreg_d   = {shreg_q[6:0], serial_in};
      bit_cnt_d = realign ? 3'd0 : bit_cnt_q + 3'd1;
   end

   // The completed byte is the post-shift value on the wrapping edge.
   assign byte_val  = shreg_d;
   assign byte_done = (bit_cnt_q == 3'd7);

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: rtl/serial_rx_unstripe.sv
// Comma-aligned serial receiver that unstripes data bytes onto two lanes.
// Optional byte_count statistics port is enabled by defining RX_STATS_EN.
module serial_rx_unstripe
   import serial_rx_unstripe_pkg::*;
(
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       serial_in,
   output logic [7:0] data_out_0,
   output logic       valid_out_0,
   output logic [7:0] data_out_1,
   output logic       valid_out_1,
   output logic       active
`ifdef RX_STATS_EN
   ,
   output logic [7:0] byte_count
`endif
);

   logic [7:0] byte_val;
   logic       byte_done;
   logic       realign;
   logic       is_comma;

   rx_state_e  state_q, state_d;
   comma_cnt_t comma_cnt_q, comma_cnt_d;
   lane_idx_t  lane_q, lane_d;

   logic       pend_vld_q, pend_vld_d;
   lane_idx_t  pend_lane_q, pend_lane_d;
   logic [7:0] pend_data_q, pend_data_d;

   logic [7:0] data0_q, data0_d;
   logic [7:0] data1_q, data1_d;
   logic       v0_q, v0_d;
   logic       v1_q, v1_d;
   logic       active_q, active_d;

   serial_to_byte u_s2b (
      .clk_8f    (clk_8f),
      .reset     (reset),
      .serial_in (serial_in),
      .realign   (realign),
      .byte_val  (byte_val),
      .byte_done (byte_done)
   );

   assign is_comma = (byte_val == COMMA);

   always_comb begin
      state_d     = state_q;
      comma_cnt_d = comma_cnt_q;
      lane_d      = lane_q;
      realign     = 1'b0;
      pend_vld_d  = 1'b0;
      pend_lane_d = pend_lane_q;
      pend_data_d = pend_data_q;
      unique case (state_q)
         ALIGN: begin
            if (is_comma) begin
               realign     = 1'b1;
               comma_cnt_d = 3'd1;
               state_d     = LOCK;
            end
         end
         LOCK: begin
            if (byte_done) begin
               if (is_comma) begin
                  comma_cnt_d = comma_cnt_q + 3'd1;
                  if (comma_cnt_d == COMMA_LOCK_COUNT)
                     state_d = ACTIVE;
               end else begin
                  comma_cnt_d = '0;
                  state_d     = ALIGN;
               end
            end
         end
         ACTIVE: begin
            if (byte_done) begin
               if (is_comma) begin
                  lane_d = '0;
               end else begin
                  pend_vld_d  = 1'b1;
                  pend_lane_d = lane_q;
                  pend_data_d = byte_val;
                  lane_d      = ~lane_q;
               end
            end
         end
         default: state_d = ALIGN;
      endcase
   end

   // Second stage: a byte staged on edge N is presented after edge N+1.
   always_comb begin
      data0_d  = data0_q;
      data1_d  = data1_q;
      v0_d     = pend_vld_q && (pend_lane_q == 1'b0);
      v1_d     = pend_vld_q && (pend_lane_q == 1'b1);
      active_d = (state_d == ACTIVE);
      if (v0_d) data0_d = pend_data_q;
      if (v1_d) data1_d = pend_data_q;
   end

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         state_q     <= ALIGN;
         comma_cnt_q <= '0;
         lane_q      <= '0;
         pend_vld_q  <= 1'b0;
         pend_lane_q <= '0;
         pend_data_q <= '0;
         data0_q     <= '0;
         data1_q     <= '0;
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         comma_cnt_q <= comma_cnt_d;
         lane_q      <= lane_d;
         pend_vld_q  <= pend_vld_d;
         pend_lane_q <= pend_lane_d;
         pend_data_q <= pend_data_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         v0_q        <= v0_d;
         v1_q        <= v1_d;
         active_q    <= active_d;
      end
   end

   assign data_out_0  = data0_q;
   assign data_out_1  = data1_q;
   assign valid_out_0 = v0_q;
   assign valid_out_1 = v1_q;
   assign active      = active_q;

`ifdef RX_STATS_EN
   logic [7:0] byte_cnt_q, byte_cnt_d;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (pend_vld_d && (byte_cnt_q != 8'hFF))
         byte_cnt_d = byte_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) byte_cnt_q <= '0;
      else        byte_cnt_q <= byte_cnt_d;
   end

   assign byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_serial_rx_unstripe.sv
// Bench for serial_rx_unstripe: bit-history model plus directed literal checks.
module tb_serial_rx_unstripe;

   logic       clk_8f = 1'b0;
   logic       reset = 1'b0;
   logic       serial_in = 1'b0;
   logic [7:0] data_out_0, data_out_1;
   logic       valid_out_0, valid_out_1, active;
`ifdef RX_STATS_EN
   logic [7:0] byte_count;
`endif

   serial_rx_unstripe dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .serial_in   (serial_in),
      .data_out_0  (data_out_0),
      .valid_out_0 (valid_out_0),
      .data_out_1  (data_out_1),
      .valid_out_1 (valid_out_1),
      .active      (active)
`ifdef RX_STATS_EN
      ,
      .byte_count  (byte_count)
`endif
   );

   always #5 clk_8f = ~clk_8f;

   int total = 0;
   int bad = 0;

   // Model state: bit history and position relative to the found boundary.
   logic [7:0] win;
   logic [7:0] m_d0, m_d1, p_byte, m_cnt;
   logic       m_v0, m_v1, m_act, aligned, p_vld, lane, p_lane;
   int         commas, phase;

   logic [8:0] evq[$];

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h want %02h at %0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic model_clear();
      win = '0; m_d0 = '0; m_d1 = '0; p_byte = '0; m_cnt = '0;
      m_v0 = 0; m_v1 = 0; m_act = 0; aligned = 0; p_vld = 0;
      lane = 0; p_lane = 0; commas = 0; phase = 0;
   endtask

   task automatic model_step(input logic b);
      m_v0 = 0;
      m_v1 = 0;
      if (p_vld) begin
         if (p_lane == 1'b0) begin m_d0 = p_byte; m_v0 = 1; end
         else begin m_d1 = p_byte; m_v1 = 1; end
         p_vld = 0;
      end
      win = {win[6:0], b};
      if (!aligned) begin
         if (win == 8'hBC) begin
            aligned = 1; commas = 1; phase = 0;
         end
      end else begin
         phase++;
         if (phase == 8) begin
            phase = 0;
            if (!m_act) begin
               if (win == 8'hBC) begin
                  commas++;
                  if (commas == 4) m_act = 1;
               end else begin
                  aligned = 0; commas = 0;
               end
            end else if (win == 8'hBC) begin
               lane = 0;
            end else begin
               p_vld = 1; p_lane = lane; p_byte = win; lane = ~lane;
               if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
         end
      end
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk_8f or negedge reset);
         if (!reset) model_clear();
         else model_step(serial_in);
      end
   end

   // Cycle compare against the model, and log every strobe the DUT raises.
   initial forever begin
      @(negedge clk_8f);
      chk("cyc_d0", data_out_0, m_d0);
      chk("cyc_d1", data_out_1, m_d1);
      chk("cyc_v0", {7'd0, valid_out_0}, {7'd0, m_v0});
      chk("cyc_v1", {7'd0, valid_out_1}, {7'd0, m_v1});
      chk("cyc_act", {7'd0, active}, {7'd0, m_act});
`ifdef RX_STATS_EN
      chk("cyc_cnt", byte_count, m_cnt);
`endif
      if (valid_out_0) evq.push_back({1'b0, data_out_0});
      if (valid_out_1) evq.push_back({1'b1, data_out_1});
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_bit(input logic b);
      serial_in = b;
      @(posedge clk_8f);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) @(posedge clk_8f);
      #1;
      reset = 1'b1;
   endtask

   task automatic expect_ev(input string name, input logic [8:0] e);
      logic [8:0] g;
      if (evq.size() == 0) begin
         chk({name, "_missing"}, 8'hEE, e[7:0]);
      end else begin
         g = evq.pop_front();
         chk({name, "_lane"}, {7'd0, g[8]}, {7'd0, e[8]});
         chk({name, "_data"}, g[7:0], e[7:0]);
      end
   endtask

   task automatic expect_none(input string name);
      chk(name, evq.size() > 255 ? 8'hFF : 8'(evq.size()), 8'd0);
      evq.delete();
   endtask

   task automatic commas_to_lock(input string name);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'hBC);
         if (i == 2) chk({name, "_act3"}, {7'd0, active}, 8'd0);
      end
      chk({name, "_act4"}, {7'd0, active}, 8'd1);
   endtask

   initial begin
      serial_in = 1'b0;
      reset = 1'b0;
      repeat (4) @(posedge clk_8f);
      #1;
      chk("rst_d0", data_out_0, 8'h00);
      chk("rst_d1", data_out_1, 8'h00);
      chk("rst_v", {6'd0, valid_out_1, valid_out_0}, 8'h00);
      chk("rst_act", {7'd0, active}, 8'd0);
      reset = 1'b1;

      // Six commas: lock on the fourth, no strobes.
      commas_to_lock("lock");
      send_byte(8'hBC);
      send_byte(8'hBC);
      chk("lock_hold", {7'd0, active}, 8'd1);
      expect_none("lock_novalid");

      // Alternating lanes.
      send_byte(8'hA4);
      send_byte(8'h32);
      send_byte(8'hFF);
      send_byte(8'h00);
      send_byte(8'hBC);
      expect_ev("s2_a4", {1'b0, 8'hA4});
      expect_ev("s2_32", {1'b1, 8'h32});
      expect_ev("s2_ff", {1'b0, 8'hFF});
      expect_ev("s2_00", {1'b1, 8'h00});
      expect_none("s2_extra");
      chk("s2_hold0", data_out_0, 8'hFF);
      chk("s2_hold1", data_out_1, 8'h00);

      // Idle comma resets the lane pointer.
      send_byte(8'hFF);
      send_byte(8'hBC);
      send_byte(8'hEE);
      send_byte(8'hBC);
      expect_ev("s3_ff", {1'b0, 8'hFF});
      expect_ev("s3_ee", {1'b0, 8'hEE});
      expect_none("s3_extra");

      // Broken comma run in LOCK forces realignment.
      do_reset(2);
      send_byte(8'hBC);
      send_byte(8'hBC);
      send_byte(8'h55);
      chk("s4_act55", {7'd0, active}, 8'd0);
      commas_to_lock("s4");
      send_byte(8'h12);
      send_byte(8'hBC);
      expect_ev("s4_12", {1'b0, 8'h12});
      expect_none("s4_extra");

      // Arbitrary bit offset before the first comma.
      do_reset(2);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      commas_to_lock("s5");
      send_byte(8'h3C);
      send_byte(8'hC3);
      send_byte(8'hBC);
      expect_ev("s5_3c", {1'b0, 8'h3C});
      expect_ev("s5_c3", {1'b1, 8'hC3});
      expect_none("s5_extra");

      // Reset in the middle of a data byte.
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("s6_pre", data_out_0, 8'h3C);
      #2;
      reset = 1'b0;
      #1;
      chk("s6_d0", data_out_0, 8'h00);
      chk("s6_d1", data_out_1, 8'h00);
      chk("s6_v", {6'd0, valid_out_1, valid_out_0}, 8'h00);
      chk("s6_act", {7'd0, active}, 8'd0);
      @(posedge clk_8f);
      #1;
      reset = 1'b1;
      commas_to_lock("s6");
      send_byte(8'h77);
      send_byte(8'hBC);
      expect_ev("s6_77", {1'b0, 8'h77});
      expect_none("s6_extra");

`ifdef RX_STATS_EN
      do_reset(2);
      commas_to_lock("s7");
      for (int i = 0; i < 300; i++) send_byte(8'h5A);
      send_byte(8'hBC);
      chk("s7_cnt", byte_count, 8'hFF);
      chk("s7_nev", evq.size() == 300 ? 8'd1 : 8'd0, 8'd1);
      evq.delete();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
